// File: rtl/global_defs.sv
// Shared types and constants for the matrix-multiply operand path.
// Imported by the feeder, its buffers and its handshake interface.
package global_defs;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/mult_operand_feeder_if.sv
// Operand-pair handshake from the feeder to the multiplier input.
// Master drives the pair and its index; slave returns the ack.
interface mult_operand_feeder_if
  import global_defs::*;
#(
  parameter int IDX_W = 3
);

  logic [FP_W-1:0]  mult_a;
  logic [FP_W-1:0]  mult_b;
  logic             mult_stb;
  logic             mult_ack;
  logic [IDX_W-1:0] issue_idx;

  modport master (
    output mult_a,
    output mult_b,
    output mult_stb,
    output issue_idx,
    input  mult_ack
  );

  modport slave (
    input  mult_a,
    input  mult_b,
    input  mult_stb,
    input  issue_idx,
    output mult_ack
  );

endinterface

// File: rtl/feeder_vec_buf.sv
// VEC_LEN x FP_W register file: one write port, one combinational
// read port, synchronous clear. Out-of-range writes are dropped.
module feeder_vec_buf
  import global_defs::*;
#(
  parameter  int VEC_LEN = 8,
  localparam int IDX_W   = $clog2(VEC_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [FP_W-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [FP_W-1:0]  rdata
);

  logic [FP_W-1:0] mem_q [VEC_LEN];
  logic [FP_W-1:0] mem_d [VEC_LEN];
  logic            wr_ok;
  logic            rd_ok;

  assign wr_ok = we && (int'(waddr) < VEC_LEN);
  assign rd_ok = int'(raddr) < VEC_LEN;

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = rd_ok ? mem_q[raddr] : '0;

endmodule

// File: rtl/mult_operand_feeder.sv
// Buffers an A row and B column, then streams index-tagged operand
// pairs to the multiplier. FEEDER_STALL_CNT_EN adds a stall counter.
module mult_operand_feeder
  import global_defs::*;
#(
  parameter  int VEC_LEN = 8,
  localparam int IDX_W   = $clog2(VEC_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_a_en,
  input  logic                 load_b_en,
  input  logic [IDX_W-1:0]     load_idx,
  input  logic [FP_W-1:0]      load_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
`ifdef FEEDER_STALL_CNT_EN
  output logic [15:0]          stall_cycles,
`endif
  mult_operand_feeder_if.master mif
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(VEC_LEN - 1);

  feeder_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] iidx_q, iidx_d;
  logic             stb_q, stb_d;
  logic [FP_W-1:0]  a_q, a_d;
  logic [FP_W-1:0]  b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [FP_W-1:0]  a_rd, b_rd;
  logic             idle;
  logic             a_we, b_we;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]      stall_q, stall_d;
`endif

  assign idle = (state_q == IDLE);
  assign a_we = idle && load_a_en;
  assign b_we = idle && load_b_en;

  feeder_vec_buf #(.VEC_LEN(VEC_LEN)) u_buf_a (
    .clk   (clk),
    .rst   (rst),
    .we    (a_we),
    .waddr (load_idx),
    .wdata (load_data),
    .raddr (idx_q),
    .rdata (a_rd)
  );

  feeder_vec_buf #(.VEC_LEN(VEC_LEN)) u_buf_b (
    .clk   (clk),
    .rst   (rst),
    .we    (b_we),
    .waddr (load_idx),
    .wdata (load_data),
    .raddr (idx_q),
    .rdata (b_rd)
  );

  // ISSUE with stb low is the fetch cycle: it lets a write made
  // alongside start land before the first pair is registered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    iidx_d  = iidx_q;
    stb_d   = stb_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef FEEDER_STALL_CNT_EN
    stall_d = stall_q;
`endif
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = ISSUE;
          idx_d   = '0;
          busy_d  = 1'b1;
`ifdef FEEDER_STALL_CNT_EN
          stall_d = '0;
`endif
        end
      end
      ISSUE: begin
        if (!stb_q) begin
          stb_d  = 1'b1;
          a_d    = a_rd;
          b_d    = b_rd;
          iidx_d = idx_q;
        end else if (mif.mult_ack) begin
          stb_d = 1'b0;
          if (idx_q == LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
`ifdef FEEDER_STALL_CNT_EN
          if (stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
          end
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        stb_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      iidx_q  <= '0;
      stb_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FEEDER_STALL_CNT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      iidx_q  <= iidx_d;
      stb_q   <= stb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FEEDER_STALL_CNT_EN
      stall_q <= stall_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mif.mult_a    = a_q;
  assign mif.mult_b    = b_q;
  assign mif.mult_stb  = stb_q;
  assign mif.issue_idx = iidx_q;
`ifdef FEEDER_STALL_CNT_EN
  assign stall_cycles  = stall_q;
`endif

endmodule

// File: tb/tb_mult_operand_feeder.sv
// Bench for mult_operand_feeder: array model of the two vectors,
// expected pair order and done timing derived from the handshake.
module tb_mult_operand_feeder;
  import global_defs::*;

  localparam int N  = 8;
  localparam int W  = 3;
  localparam int N5 = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        la, lb;
  logic [W-1:0] lidx;
  logic [31:0] ldata;
  logic        start;
  logic        busy, done;
  logic        la5;
  logic [W-1:0] lidx5;
  logic [31:0] ldata5;
  logic        start5;
  logic        busy5, done5;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] stall5;
`endif

  mult_operand_feeder_if #(.IDX_W(W)) mif ();
  mult_operand_feeder_if #(.IDX_W(W)) mif5 ();

  mult_operand_feeder #(.VEC_LEN(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_a_en    (la),
    .load_b_en    (lb),
    .load_idx     (lidx),
    .load_data    (ldata),
    .start        (start),
    .busy         (busy),
    .done         (done),
`ifdef FEEDER_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .mif          (mif.master)
  );

  mult_operand_feeder #(.VEC_LEN(N5)) dut5 (
    .clk          (clk),
    .rst          (rst),
    .load_a_en    (la5),
    .load_b_en    (1'b0),
    .load_idx     (lidx5),
    .load_data    (ldata5),
    .start        (start5),
    .busy         (busy5),
    .done         (done5),
`ifdef FEEDER_STALL_CNT_EN
    .stall_cycles (stall5),
`endif
    .mif          (mif5.master)
  );

  always #5 clk = ~clk;

  logic [31:0] ref_a [N];
  logic [31:0] ref_b [N];
  logic [31:0] ref5  [N5];
  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      ref_a[i] = '0;
      ref_b[i] = '0;
    end
    for (int i = 0; i < N5; i++) ref5[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic load_word(input bit ea, input bit eb,
                           input int idx, input logic [31:0] d);
    la = ea;
    lb = eb;
    lidx = W'(idx);
    ldata = d;
    tick();
    la = 1'b0;
    lb = 1'b0;
    if (idx < N) begin
      if (ea) ref_a[idx] = d;
      if (eb) ref_b[idx] = d;
    end
  endtask

  // One start-to-done run; optional stall, random ack, a write made
  // while busy, reset at an index, or a write alongside start.
  task automatic run(input int stall_idx, input int stall_n,
                     input bit rnd, input int inj_idx,
                     input int abort_idx, input bit pre_load,
                     input logic [31:0] pre_data);
    int  k, stalls, left;
    bit  prev_x, inj, fin;
    k = 0;
    stalls = 0;
    left = stall_n;
    prev_x = 0;
    inj = 0;
    fin = 0;
    mif.mult_ack = 1'b1;
    if (pre_load) begin
      la = 1'b1;
      lidx = '0;
      ldata = pre_data;
      ref_a[0] = pre_data;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    la = 1'b0;
    for (int c = 1; c <= 600 && !fin; c++) begin
      if (k == N) begin
        chk("done_cycle", 64'(c), 64'(2 * N + 1 + stalls));
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_stb", mif.mult_stb, 0);
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, 64'(stalls));
`endif
        tick();
        chk("after_done", done, 0);
        chk("after_busy", busy, 0);
        fin = 1;
      end else if (abort_idx >= 0 && mif.mult_stb &&
                   int'(mif.issue_idx) == abort_idx) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        chk("abort_stb", mif.mult_stb, 0);
        chk("abort_busy", busy, 0);
        fin = 1;
      end else begin
        chk("busy", busy, 1);
        chk("no_early_done", done, 0);
        if (prev_x) chk("stb_gap", mif.mult_stb, 0);
        if (mif.mult_stb) begin
          chk("issue_idx", mif.issue_idx, 64'(k));
          chk("mult_a", mif.mult_a, ref_a[k]);
          chk("mult_b", mif.mult_b, ref_b[k]);
        end
        if (inj_idx >= 0 && !inj && mif.mult_stb &&
            int'(mif.issue_idx) == inj_idx) begin
          la = 1'b1;
          lidx = W'(inj_idx);
          ldata = 32'hDEADBEEF;
          inj = 1;
        end
        prev_x = 0;
        if (mif.mult_stb) begin
          if (stall_idx == k && left > 0) begin
            mif.mult_ack = 1'b0;
            left--;
            stalls++;
          end else if (rnd && $urandom_range(0, 2) == 0) begin
            mif.mult_ack = 1'b0;
            stalls++;
          end else begin
            mif.mult_ack = 1'b1;
            prev_x = 1;
            k++;
          end
        end else begin
          mif.mult_ack = 1'($urandom_range(0, 1));
        end
        tick();
        la = 1'b0;
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    mif.mult_ack = 1'b1;
  endtask

  logic [31:0] fp_tab [N];
  int cnt5;
  bit fin5;

  initial begin
    fp_tab = '{32'h3F800000, 32'h40000000, 32'h40400000,
               32'h40800000, 32'h40A00000, 32'h40C00000,
               32'h40E00000, 32'h41000000};
    rst = 1'b1;
    la = 0; lb = 0; lidx = '0; ldata = '0; start = 0;
    la5 = 0; lidx5 = '0; ldata5 = '0; start5 = 0;
    mif.mult_ack = 1'b1;
    mif5.mult_ack = 1'b1;
    do_reset();

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stb", mif.mult_stb, 0);
    chk("rst_a", mif.mult_a, 0);
    chk("rst_b", mif.mult_b, 0);
    chk("rst_idx", mif.issue_idx, 0);
`ifdef FEEDER_STALL_CNT_EN
    chk("rst_stall", stall_cycles, 0);
`endif

    for (int i = 0; i < N; i++) load_word(1, 0, i, fp_tab[i]);
    for (int i = 0; i < N; i++) load_word(0, 1, i, 32'h40000000);
    run(-1, 0, 0, -1, -1, 0, '0);

    run(3, 5, 0, -1, -1, 0, '0);

    run(-1, 0, 0, 2, -1, 0, '0);
    run(-1, 0, 0, -1, -1, 0, '0);

    run(-1, 0, 0, -1, 4, 0, '0);
    tick();
    run(-1, 0, 0, -1, -1, 0, '0);

    for (int i = 0; i < N; i++) load_word(1, 1, i, fp_tab[i]);
    run(-1, 0, 0, -1, -1, 1, 32'h12345678);

    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 20; j++) begin
        load_word(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, N - 1), $urandom);
      end
      run(-1, 0, 1, -1, -1, 0, '0);
    end

    do_reset();
    for (int i = 0; i < N; i++) begin
      la5 = 1'b1;
      lidx5 = W'(i);
      ldata5 = 32'hA0000000 + 32'(i);
      tick();
      if (i < N5) ref5[i] = 32'hA0000000 + 32'(i);
    end
    la5 = 1'b0;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    cnt5 = 0;
    fin5 = 0;
    for (int c = 0; c < 60 && !fin5; c++) begin
      if (mif5.mult_stb) begin
        chk("v5_idx", mif5.issue_idx, 64'(cnt5));
        if (cnt5 < N5) chk("v5_a", mif5.mult_a, ref5[cnt5]);
        cnt5++;
      end
      if (done5) begin
        chk("v5_count", 64'(cnt5), 64'(N5));
        fin5 = 1;
      end
      tick();
    end
    if (!fin5) chk("v5_timeout", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
